// File: rtl/inv_mix_columns_stage.sv
// inv_mix_columns_stage: two-stage pipelined AES (Inv)MixColumns on a 128-bit state
// with valid/ready handshake on both sides.
// Optional build macro IMC_LAST_ROUND_BYPASS_EN adds a Bypass input that lets a
// word pass through untransformed (final AES round) with the same latency.
module inv_mix_columns_stage (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] InData,
  input  logic         Inv,
`ifdef IMC_LAST_ROUND_BYPASS_EN
  input  logic         Bypass,
`endif
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] OutData
);

  localparam int unsigned DW = 128;
  localparam int unsigned NB = DW / 8;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic          adv1;
  logic          adv2;

  logic          s1_v;
  logic          s1_inv;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_x2;
  logic [DW-1:0] s1_x4;
  logic [DW-1:0] s1_x8;
`ifdef IMC_LAST_ROUND_BYPASS_EN
  logic          s1_byp;
`endif

  logic          s2_v;
  logic [DW-1:0] s2_d;

  logic [DW-1:0] in_x2;
  logic [DW-1:0] in_x4;
  logic [DW-1:0] in_x8;
  logic [DW-1:0] mix;
  logic [DW-1:0] s2_nxt;

  // Pipeline advance: a stage moves when it is empty or the stage after it moves
  assign adv2     = !s2_v || OutReady;
  assign adv1     = !s1_v || adv2;
  assign InReady  = adv1 && !Rst;
  assign OutValid = s2_v;
  assign OutData  = s2_d;

  // Per-byte doubling chain feeding stage 1 (byte positions preserved)
  for (genvar gb = 0; gb < NB; gb++) begin : g_mul
    assign in_x2[8*gb +: 8] = xtime(InData[8*gb +: 8]);
    assign in_x4[8*gb +: 8] = xtime(in_x2[8*gb +: 8]);
    assign in_x8[8*gb +: 8] = xtime(in_x4[8*gb +: 8]);
  end

  // Column mixing from registered partial products; row r uses a_r..a_(r+3) mod 4
  for (genvar gc = 0; gc < 4; gc++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      localparam int P0 = 127 - 32*gc - 8*gr;
      localparam int P1 = 127 - 32*gc - 8*((gr + 1) % 4);
      localparam int P2 = 127 - 32*gc - 8*((gr + 2) % 4);
      localparam int P3 = 127 - 32*gc - 8*((gr + 3) % 4);

      logic [7:0] fwd_b;
      logic [7:0] inv_b;

      // 02*a0 ^ 03*a1 ^ a2 ^ a3
      assign fwd_b = s1_x2[P0 -: 8]
                   ^ s1_x2[P1 -: 8] ^ s1_a[P1 -: 8]
                   ^ s1_a[P2 -: 8]
                   ^ s1_a[P3 -: 8];

      // 0E*a0 ^ 0B*a1 ^ 0D*a2 ^ 09*a3
      assign inv_b = (s1_x8[P0 -: 8] ^ s1_x4[P0 -: 8] ^ s1_x2[P0 -: 8])
                   ^ (s1_x8[P1 -: 8] ^ s1_x2[P1 -: 8] ^ s1_a[P1 -: 8])
                   ^ (s1_x8[P2 -: 8] ^ s1_x4[P2 -: 8] ^ s1_a[P2 -: 8])
                   ^ (s1_x8[P3 -: 8] ^ s1_a[P3 -: 8]);

      assign mix[P0 -: 8] = s1_inv ? inv_b : fwd_b;
    end
  end

  // Final-round words skip the mixing when the bypass option is built in
`ifdef IMC_LAST_ROUND_BYPASS_EN
  assign s2_nxt = s1_byp ? s1_a : mix;
`else
  assign s2_nxt = mix;
`endif

  // Stage 1: capture raw bytes, their x2/x4/x8 multiples and the word's mode bits
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_v   <= 1'b0;
      s1_inv <= 1'b0;
      s1_a   <= '0;
      s1_x2  <= '0;
      s1_x4  <= '0;
      s1_x8  <= '0;
`ifdef IMC_LAST_ROUND_BYPASS_EN
      s1_byp <= 1'b0;
`endif
    end else if (adv1) begin
      s1_v   <= InValid && InReady;
      s1_inv <= Inv;
      s1_a   <= InData;
      s1_x2  <= in_x2;
      s1_x4  <= in_x4;
      s1_x8  <= in_x8;
`ifdef IMC_LAST_ROUND_BYPASS_EN
      s1_byp <= Bypass;
`endif
    end
  end

  // Stage 2: register the combined column results; holds under backpressure
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s2_v <= 1'b0;
      s2_d <= '0;
    end else if (adv2) begin
      s2_v <= s1_v;
      s2_d <= s2_nxt;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_stage.sv
// Directed testbench for inv_mix_columns_stage using known AES MixColumns vectors.
// Define IMC_LAST_ROUND_BYPASS_EN for both files to exercise the bypass option.
module tb_inv_mix_columns_stage;

  logic         Clk;
  logic         Rst;
  logic         InValid;
  logic         InReady;
  logic [127:0] InData;
  logic         Inv;
`ifdef IMC_LAST_ROUND_BYPASS_EN
  logic         Bypass;
`endif
  logic         OutValid;
  logic         OutReady;
  logic [127:0] OutData;

  int n_pass;
  int n_total;

  inv_mix_columns_stage dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .InData   (InData),
    .Inv      (Inv),
`ifdef IMC_LAST_ROUND_BYPASS_EN
    .Bypass   (Bypass),
`endif
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutData  (OutData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    mk = {c0, c1, c2, c3};
  endfunction

  // Known forward MixColumns column pairs: col_a -> col_b (and col_b -> col_a inverse)
  function automatic logic [31:0] col_a(input int p);
    case (p)
      0:       col_a = 32'hdb135345;
      1:       col_a = 32'hf20a225c;
      2:       col_a = 32'h01010101;
      3:       col_a = 32'h2d26314c;
      4:       col_a = 32'hc6c6c6c6;
      default: col_a = 32'hd4d4d4d5;
    endcase
  endfunction

  function automatic logic [31:0] col_b(input int p);
    case (p)
      0:       col_b = 32'h8e4da1bc;
      1:       col_b = 32'h9fdc589d;
      2:       col_b = 32'h01010101;
      3:       col_b = 32'h4d7ebdf8;
      4:       col_b = 32'hc6c6c6c6;
      default: col_b = 32'hd5d5d7d6;
    endcase
  endfunction

  // Stream word k: even k forward (input col_a), odd k inverse (input col_b)
  function automatic logic [127:0] w_in(input int k);
    logic [127:0] w;
    w = '0;
    for (int c = 0; c < 4; c++)
      w[127 - 32*c -: 32] = (k % 2 == 1) ? col_b((k + c) % 6) : col_a((k + c) % 6);
    w_in = w;
  endfunction

  function automatic logic [127:0] w_exp(input int k);
    logic [127:0] w;
    w = '0;
    for (int c = 0; c < 4; c++)
      w[127 - 32*c -: 32] = (k % 2 == 1) ? col_a((k + c) % 6) : col_b((k + c) % 6);
    w_exp = w;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL reset_outvalid: got %b want 0", OutValid);
    else n_pass++;
    n_total++;
    if (OutData !== 128'h0) $display("FAIL reset_outdata: got %h want 0", OutData);
    else n_pass++;
    n_total++;
    if (InReady !== 1'b0) $display("FAIL reset_inready: got %b want 0", InReady);
    else n_pass++;
    Rst = 1'b0;
    #1;
    n_total++;
    if (InReady !== 1'b1) $display("FAIL post_reset_inready: got %b want 1", InReady);
    else n_pass++;
    tick();
  endtask

  task automatic test_forward();
    OutReady = 1'b1;
    InValid  = 1'b1;
    Inv      = 1'b0;
    InData   = mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
    #1;
    n_total++;
    if (InReady !== 1'b1) $display("FAIL fwd_inready: got %b want 1", InReady);
    else n_pass++;
    tick();
    InValid = 1'b0;
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL fwd_early_valid: got %b want 0", OutValid);
    else n_pass++;
    tick();
    n_total++;
    if (OutValid !== 1'b1) $display("FAIL fwd_latency: got %b want 1", OutValid);
    else n_pass++;
    n_total++;
    if (OutData !== mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc))
      $display("FAIL fwd_data: got %h want 8e4da1bc x4", OutData);
    else n_pass++;
    tick();
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL fwd_single_pulse: got %b want 0", OutValid);
    else n_pass++;
  endtask

  task automatic test_inverse();
    OutReady = 1'b1;
    InValid  = 1'b1;
    Inv      = 1'b1;
    InData   = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
    tick();
    InValid = 1'b0;
    Inv     = 1'b0;
    tick();
    n_total++;
    if (OutValid !== 1'b1) $display("FAIL inv_latency: got %b want 1", OutValid);
    else n_pass++;
    n_total++;
    if (OutData !== mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c))
      $display("FAIL inv_data: got %h want db135345f20a225c010101012d26314c", OutData);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 8) begin
        InValid = 1'b1;
        InData  = w_in(cyc);
        Inv     = 1'(cyc % 2);
        #1;
        n_total++;
        if (InReady !== 1'b1) $display("FAIL b2b_inready[%0d]: got %b want 1", cyc, InReady);
        else n_pass++;
      end else begin
        InValid = 1'b0;
      end
      tick();
      if (cyc >= 1 && cyc <= 8) begin
        n_total++;
        if (OutValid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", cyc - 1, OutValid);
        else n_pass++;
        n_total++;
        if (OutData !== w_exp(cyc - 1))
          $display("FAIL b2b_data[%0d]: got %h want %h", cyc - 1, OutData, w_exp(cyc - 1));
        else n_pass++;
      end else if (cyc == 9) begin
        n_total++;
        if (OutValid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", OutValid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit exp_ir  [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit exp_ov  [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int exp_idx [12] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 5, 0};
    int nin;
    nin = 0;
    for (int k = 0; k < 12; k++) begin
      OutReady = (k >= 5);
      if (nin < 6) begin
        InValid = 1'b1;
        InData  = w_in(nin);
        Inv     = 1'(nin % 2);
      end else begin
        InValid = 1'b0;
      end
      #1;
      n_total++;
      if (InReady !== exp_ir[k]) $display("FAIL bp_inready[%0d]: got %b want %b", k, InReady, exp_ir[k]);
      else n_pass++;
      n_total++;
      if (OutValid !== exp_ov[k]) $display("FAIL bp_valid[%0d]: got %b want %b", k, OutValid, exp_ov[k]);
      else n_pass++;
      if (exp_ov[k]) begin
        n_total++;
        if (OutData !== w_exp(exp_idx[k]))
          $display("FAIL bp_data[%0d]: got %h want %h", k, OutData, w_exp(exp_idx[k]));
        else n_pass++;
      end
      if (InValid && exp_ir[k]) nin++;
      tick();
    end
    InValid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    OutReady = 1'b0;
    InValid  = 1'b1;
    InData   = w_in(0);
    Inv      = 1'b0;
    tick();
    InData = w_in(1);
    Inv    = 1'b1;
    tick();
    InValid = 1'b0;
    n_total++;
    if (OutValid !== 1'b1 || OutData !== w_exp(0))
      $display("FAIL rstmid_held: got %b/%h want 1/%h", OutValid, OutData, w_exp(0));
    else n_pass++;
    Rst = 1'b1;
    #1;
    n_total++;
    if (InReady !== 1'b0) $display("FAIL rstmid_inready: got %b want 0", InReady);
    else n_pass++;
    tick();
    Rst = 1'b0;
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", OutValid);
    else n_pass++;
    n_total++;
    if (OutData !== 128'h0) $display("FAIL rstmid_data: got %h want 0", OutData);
    else n_pass++;
    OutReady = 1'b1;
    InValid  = 1'b1;
    InData   = w_in(2);
    Inv      = 1'b0;
    #1;
    n_total++;
    if (InReady !== 1'b1) $display("FAIL rstmid_accept: got %b want 1", InReady);
    else n_pass++;
    tick();
    InValid = 1'b0;
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL rstmid_no_stale: got %b want 0", OutValid);
    else n_pass++;
    tick();
    n_total++;
    if (OutValid !== 1'b1 || OutData !== w_exp(2))
      $display("FAIL rstmid_new_word: got %b/%h want 1/%h", OutValid, OutData, w_exp(2));
    else n_pass++;
    tick();
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL rstmid_tail: got %b want 0", OutValid);
    else n_pass++;
  endtask

`ifdef IMC_LAST_ROUND_BYPASS_EN
  task automatic test_bypass();
    OutReady = 1'b1;
    InValid  = 1'b1;
    Inv      = 1'b1;
    Bypass   = 1'b1;
    InData   = 128'h00112233445566778899aabbccddeeff;
    tick();
    InValid = 1'b0;
    Bypass  = 1'b0;
    n_total++;
    if (OutValid !== 1'b0) $display("FAIL byp_early_valid: got %b want 0", OutValid);
    else n_pass++;
    tick();
    n_total++;
    if (OutValid !== 1'b1 || OutData !== 128'h00112233445566778899aabbccddeeff)
      $display("FAIL byp_data: got %b/%h want 1/00112233445566778899aabbccddeeff", OutValid, OutData);
    else n_pass++;
    tick();
  endtask
`endif

  initial begin
    n_pass   = 0;
    n_total  = 0;
    Rst      = 1'b1;
    InValid  = 1'b0;
    InData   = '0;
    Inv      = 1'b0;
    OutReady = 1'b0;
`ifdef IMC_LAST_ROUND_BYPASS_EN
    Bypass   = 1'b0;
`endif
    #1;
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef IMC_LAST_ROUND_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
